// File: rtl/instruction_fetcher.sv
// instruction_fetcher: PC generation, i_cache fetch, static/BHT next-PC prediction and queue push.
module instruction_fetcher #(
  parameter int          BHT_BITS = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        ic_ins_asked,
  output logic [31:0] ic_ins_addr,
  input  logic        ic_ins_rdy,
  input  logic [31:0] ic_ins,
  input  logic        dq_full,
  output logic        dq_ins_valid,
  output logic [31:0] dq_ins,
  output logic [31:0] dq_pc,
  output logic        dq_pred_taken,
  output logic [31:0] dq_pred_pc,
  input  logic        rob_clear,
  input  logic [31:0] rob_new_pc,
  input  logic        bp_upd_valid,
  input  logic [31:0] bp_upd_pc,
  input  logic        bp_upd_taken
);
  typedef enum logic [1:0] {IDLE, WAIT, HOLD, GAP} state_t;
  state_t      state, state_d;
  logic [31:0] pc, pc_d, pend_pc, pend_d, addr_d, ins_d, dpc_d, ppc_d;
  logic        discard, discard_d, asked_d, valid_d, taken_d;
  logic [1:0]  bht [2**BHT_BITS];
  logic [1:0]  bht_rd, bht_cur, bht_nx;
  logic [31:0] j_imm, b_imm, pred_pc;
  logic        is_jal, is_br, pred_taken;
  logic        unused_bits;
  assign unused_bits = &{1'b0, bp_upd_pc[31:BHT_BITS+2], bp_upd_pc[1:0]};
  // The instruction being returned always belongs to ic_ins_addr, which is frozen during WAIT.
  always_comb begin
    is_jal     = ic_ins[6:0] == 7'b1101111;
    is_br      = ic_ins[6:0] == 7'b1100011;
    j_imm      = {{11{ic_ins[31]}}, ic_ins[31], ic_ins[19:12], ic_ins[20], ic_ins[30:21], 1'b0};
    b_imm      = {{19{ic_ins[31]}}, ic_ins[31], ic_ins[7], ic_ins[30:25], ic_ins[11:8], 1'b0};
    bht_rd     = bht[ic_ins_addr[BHT_BITS+1:2]];
    pred_taken = is_jal | (is_br & bht_rd[1]);
    pred_pc    = is_jal ? ic_ins_addr + j_imm : pred_taken ? ic_ins_addr + b_imm : ic_ins_addr + 32'd4;
    bht_cur    = bht[bp_upd_pc[BHT_BITS+1:2]];
    bht_nx     = bp_upd_taken ? (bht_cur == 2'd3 ? 2'd3 : bht_cur + 2'd1)
                              : (bht_cur == 2'd0 ? 2'd0 : bht_cur - 2'd1);
  end
  always_comb begin
    state_d   = state;
    pc_d      = pc;
    pend_d    = pend_pc;
    discard_d = discard;
    asked_d   = ic_ins_asked;
    addr_d    = ic_ins_addr;
    valid_d   = 1'b0;
    ins_d     = dq_ins;
    dpc_d     = dq_pc;
    taken_d   = dq_pred_taken;
    ppc_d     = dq_pred_pc;
    unique case (state)
      IDLE: begin
        if (rob_clear) pc_d = rob_new_pc;
        else begin
          asked_d = 1'b1;
          addr_d  = pc;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (ic_ins_rdy) begin
          asked_d = 1'b0;
          if (discard || rob_clear) begin
            pc_d      = rob_clear ? rob_new_pc : pend_pc;
            discard_d = 1'b0;
            state_d   = GAP;
          end else begin
            ins_d   = ic_ins;
            dpc_d   = ic_ins_addr;
            taken_d = pred_taken;
            ppc_d   = pred_pc;
            state_d = HOLD;
          end
        end else if (rob_clear) begin
          discard_d = 1'b1;
          pend_d    = rob_new_pc;
        end
      end
      HOLD: begin
        if (rob_clear) begin
          pc_d    = rob_new_pc;
          state_d = IDLE;
        end else if (!dq_full) begin
          valid_d = 1'b1;
          pc_d    = dq_pred_pc;
          state_d = IDLE;
        end
      end
      default: begin
        if (rob_clear) pc_d = rob_new_pc;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      pend_pc       <= '0;
      discard       <= 1'b0;
      ic_ins_asked  <= 1'b0;
      ic_ins_addr   <= '0;
      dq_ins_valid  <= 1'b0;
      dq_ins        <= '0;
      dq_pc         <= '0;
      dq_pred_taken <= 1'b0;
      dq_pred_pc    <= '0;
      for (int i = 0; i < 2**BHT_BITS; i++) bht[i] <= 2'b01;
    end else begin
      dq_ins_valid <= rdy && valid_d;
      if (rdy) begin
        state         <= state_d;
        pc            <= pc_d;
        pend_pc       <= pend_d;
        discard       <= discard_d;
        ic_ins_asked  <= asked_d;
        ic_ins_addr   <= addr_d;
        dq_ins        <= ins_d;
        dq_pc         <= dpc_d;
        dq_pred_taken <= taken_d;
        dq_pred_pc    <= ppc_d;
        if (bp_upd_valid) bht[bp_upd_pc[BHT_BITS+1:2]] <= bht_nx;
      end
    end
  end
endmodule

// File: tb/tb_instruction_fetcher.sv
// tb_instruction_fetcher: vector table, directed corner sequences and a random walk vs a behavioural model.
module tb_instruction_fetcher;
  logic        clk = 0, rst = 1, rdy = 1;
  logic        ic_ins_asked, ic_ins_rdy = 0, dq_full = 0, dq_ins_valid, dq_pred_taken;
  logic [31:0] ic_ins_addr, ic_ins = 0, dq_ins, dq_pc, dq_pred_pc;
  logic        rob_clear = 0, bp_upd_valid = 0, bp_upd_taken = 0;
  logic [31:0] rob_new_pc = 0, bp_upd_pc = 0;
  int          n_vec = 0, n_bad = 0;
  localparam logic [31:0] ADDI = 32'h00100093;
  instruction_fetcher dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .ic_ins_asked(ic_ins_asked), .ic_ins_addr(ic_ins_addr), .ic_ins_rdy(ic_ins_rdy), .ic_ins(ic_ins),
    .dq_full(dq_full), .dq_ins_valid(dq_ins_valid), .dq_ins(dq_ins), .dq_pc(dq_pc),
    .dq_pred_taken(dq_pred_taken), .dq_pred_pc(dq_pred_pc),
    .rob_clear(rob_clear), .rob_new_pc(rob_new_pc),
    .bp_upd_valid(bp_upd_valid), .bp_upd_pc(bp_upd_pc), .bp_upd_taken(bp_upd_taken));
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
  typedef struct {
    logic [31:0] pc, ins, upd_pc;
    logic [7:0]  pat;
    int          n;
    logic        taken;
    logic [31:0] ppc;
  } vec_t;
  typedef struct { logic [31:0] ins; int kind; int off; } mem_t;
  typedef struct { logic [31:0] ins, pc; logic taken; logic [31:0] ppc; } push_t;
  vec_t  vt[$];
  mem_t  mem[64];
  push_t exp_q[$];
  int    bhtm[256];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [31:0] enc_jal(input int off);
    logic [31:0] o = off;
    return {o[20], o[10:1], o[11], o[19:12], 5'd0, 7'b1101111};
  endfunction
  function automatic logic [31:0] enc_b(input int off);
    logic [31:0] o = off;
    return {o[12], o[10:5], 5'd2, 5'd1, 3'b000, o[4:1], o[11], 7'b1100011};
  endfunction
  task automatic do_reset();
    rst = 1; rdy = 1; ic_ins_rdy = 0; dq_full = 0; rob_clear = 0; bp_upd_valid = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask
  task automatic chk_reset(input string nm);
    chk({nm, "_asked"}, 32'(ic_ins_asked), 0);
    chk({nm, "_addr"}, ic_ins_addr, 0);
    chk({nm, "_valid"}, 32'(dq_ins_valid), 0);
    chk({nm, "_dq"}, dq_ins | dq_pc | dq_pred_pc | 32'(dq_pred_taken), 0);
  endtask
  task automatic wait_ask(input string nm, input logic [31:0] exp);
    for (int i = 0; i < 40 && !ic_ins_asked; i++) @(negedge clk);
    chk({nm, "_asked"}, 32'(ic_ins_asked), 1);
    chk(nm, ic_ins_addr, exp);
  endtask
  task automatic wait_push(input string nm);
    for (int i = 0; i < 40 && !dq_ins_valid; i++) @(negedge clk);
    chk({nm, "_valid"}, 32'(dq_ins_valid), 1);
  endtask
  task automatic respond(input logic [31:0] ins);
    ic_ins = ins; ic_ins_rdy = 1;
    @(negedge clk);
    ic_ins_rdy = 0;
  endtask
  task automatic run_vec(input int k, input vec_t v);
    string s = $sformatf("v%0d", k);
    do_reset();
    rob_clear = 1; rob_new_pc = v.pc;
    for (int i = 0; i < v.n; i++) begin
      bp_upd_valid = 1; bp_upd_pc = v.upd_pc; bp_upd_taken = v.pat[i];
      @(negedge clk);
    end
    bp_upd_valid = 0;
    @(negedge clk);
    rob_clear = 0;
    wait_ask({s, "_ask"}, v.pc);
    respond(v.ins);
    wait_push(s);
    chk({s, "_pc"}, dq_pc, v.pc);
    chk({s, "_ins"}, dq_ins, v.ins);
    chk({s, "_taken"}, 32'(dq_pred_taken), 32'(v.taken));
    chk({s, "_ppc"}, dq_pred_pc, v.ppc);
    @(negedge clk);
    chk({s, "_single"}, 32'(dq_ins_valid), 0);
    wait_ask({s, "_next"}, v.ppc);
  endtask
  initial begin
    int          cnt, npush;
    bit          serving;
    logic [31:0] saddr, exp_fetch;
    push_t       e;
    mem_t        m;
    do_reset();
    chk_reset("reset");
    vt.push_back('{32'h0,   ADDI, 32'h0, 8'h00, 0, 1'b0, 32'h4});
    vt.push_back('{32'h4,   ADDI, 32'h4, 8'h00, 0, 1'b0, 32'h8});
    vt.push_back('{32'h8,   ADDI, 32'h8, 8'h00, 0, 1'b0, 32'hC});
    vt.push_back('{32'h20,  32'h0100006F, 32'h20, 8'h00, 0, 1'b1, 32'h30});
    vt.push_back('{32'h0,   enc_jal(-4), 32'h0, 8'h00, 0, 1'b1, 32'hFFFF_FFFC});
    vt.push_back('{32'h100, enc_jal(32'h1800), 32'h100, 8'h00, 0, 1'b1, 32'h1900});
    vt.push_back('{32'h0,   enc_jal(-1048576), 32'h0, 8'h00, 0, 1'b1, 32'hFFF0_0000});
    vt.push_back('{32'h40,  enc_b(-8), 32'h40, 8'h00, 0, 1'b0, 32'h44});
    vt.push_back('{32'h40,  enc_b(-8), 32'h40, 8'h03, 2, 1'b1, 32'h38});
    vt.push_back('{32'h40,  enc_b(-8), 32'h40, 8'h07, 4, 1'b1, 32'h38});
    vt.push_back('{32'h40,  enc_b(-8), 32'h40, 8'h0C, 4, 1'b1, 32'h38});
    vt.push_back('{32'h40,  enc_b(-8), 32'h40, 8'h00, 1, 1'b0, 32'h44});
    vt.push_back('{32'h50,  32'h00008067, 32'h50, 8'h00, 0, 1'b0, 32'h54});
    vt.push_back('{32'h60,  enc_b(16), 32'h60, 8'h01, 1, 1'b1, 32'h70});
    vt.push_back('{32'h60,  enc_b(16), 32'h64, 8'h03, 2, 1'b0, 32'h64});
    vt.push_back('{32'h460, enc_b(16), 32'h60, 8'h03, 2, 1'b1, 32'h470});
    foreach (vt[k]) run_vec(k, vt[k]);
    // Redirect while a miss is outstanding: address must hold, response is dropped.
    do_reset();
    rob_clear = 1; rob_new_pc = 32'h80;
    @(negedge clk);
    rob_clear = 0;
    wait_ask("t4_ask", 32'h80);
    rob_clear = 1; rob_new_pc = 32'h100;
    @(negedge clk);
    rob_clear = 0;
    for (int i = 0; i < 20; i++) begin
      chk("t4_hold_addr", ic_ins_addr, 32'h80);
      chk("t4_hold_asked", 32'(ic_ins_asked), 1);
      @(negedge clk);
    end
    respond(ADDI);
    for (int i = 0; i < 6; i++) begin
      chk("t4_no_push", 32'(dq_ins_valid), 0);
      @(negedge clk);
    end
    wait_ask("t4_redirect", 32'h100);
    rob_clear = 1; rob_new_pc = 32'h140;
    @(negedge clk);
    rob_new_pc = 32'h180; ic_ins = ADDI; ic_ins_rdy = 1;
    @(negedge clk);
    rob_clear = 0; ic_ins_rdy = 0;
    for (int i = 0; i < 6; i++) begin
      chk("t4b_no_push", 32'(dq_ins_valid), 0);
      @(negedge clk);
    end
    wait_ask("t4b_redirect", 32'h180);
    // Queue back-pressure with a stray cache pulse during HOLD.
    do_reset();
    dq_full = 1;
    wait_ask("t5_ask", 32'h0);
    respond(ADDI);
    for (int i = 0; i < 5; i++) begin
      chk("t5_blocked", 32'(dq_ins_valid), 0);
      ic_ins_rdy = (i == 2); ic_ins = 32'h0020_0113;
      @(negedge clk);
    end
    ic_ins_rdy = 0; dq_full = 0; npush = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (dq_ins_valid) begin
        npush++;
        chk("t5_ins", dq_ins, ADDI);
        chk("t5_pc", dq_pc, 32'h0);
      end
    end
    chk("t5_count", npush, 1);
    wait_ask("t5_next", 32'h4);
    dq_full = 1;
    respond(ADDI);
    rob_clear = 1; rob_new_pc = 32'h300;
    @(negedge clk);
    rob_clear = 0; dq_full = 0;
    for (int i = 0; i < 4; i++) begin
      chk("t5_clear_no_push", 32'(dq_ins_valid), 0);
      @(negedge clk);
    end
    wait_ask("t5_clear", 32'h300);
    // Freeze in WAIT and HOLD, then reset out of HOLD.
    do_reset();
    wait_ask("t6_ask", 32'h0);
    rdy = 0; ic_ins = 32'h0100006F; ic_ins_rdy = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_frz_asked", 32'(ic_ins_asked), 1);
      chk("t6_frz_addr", ic_ins_addr, 32'h0);
      chk("t6_frz_valid", 32'(dq_ins_valid), 0);
    end
    rdy = 1; ic_ins_rdy = 0;
    respond(ADDI);
    rdy = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_frz_hold", 32'(dq_ins_valid), 0);
    end
    rdy = 1;
    wait_push("t6_push");
    chk("t6_push_pc", dq_pc, 32'h0);
    chk("t6_push_ppc", dq_pred_pc, 32'h4);
    wait_ask("t6_next", 32'h4);
    dq_full = 1;
    respond(ADDI);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0; dq_full = 0;
    chk("t6_rst_valid", 32'(dq_ins_valid), 0);
    chk("t6_rst_asked", 32'(ic_ins_asked), 0);
    wait_ask("t6_rst_ask", 32'h0);
    chk("t6_rst_no_push", 32'(dq_ins_valid), 0);
    // Random walk through a small program against a counter-based prediction model.
    foreach (mem[i]) begin
      mem[i].kind = $urandom_range(0, 3);
      mem[i].off  = $urandom_range(1, 6) * 4;
      if ($urandom_range(0, 1) == 1) mem[i].off = -mem[i].off;
      mem[i].ins  = mem[i].kind == 1 ? enc_jal(mem[i].off) : mem[i].kind == 2 ? enc_b(mem[i].off) :
                    mem[i].kind == 3 ? 32'h00008067 : {12'($urandom_range(0, 4095)), 20'h00093};
    end
    foreach (bhtm[i]) bhtm[i] = 1;
    do_reset();
    serving = 0; exp_fetch = 0; saddr = 0; npush = 0; cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (dq_ins_valid) begin
        npush++;
        chk("rand_push_while_full", 32'(dq_full), 0);
        if (exp_q.size() == 0) chk("rand_unexpected_push", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("rand_pc", dq_pc, e.pc);
          chk("rand_ins", dq_ins, e.ins);
          chk("rand_taken", 32'(dq_pred_taken), 32'(e.taken));
          chk("rand_ppc", dq_pred_pc, e.ppc);
        end
      end
      if (ic_ins_asked && !serving) begin
        serving = 1; cnt = $urandom_range(0, 2); saddr = ic_ins_addr;
        chk("rand_req_addr", ic_ins_addr, exp_fetch);
      end else if (serving) chk("rand_addr_stable", ic_ins_addr, saddr);
      ic_ins_rdy = 0;
      if (serving) begin
        if (cnt == 0) begin
          m = mem[saddr[7:2]];
          ic_ins = m.ins; ic_ins_rdy = 1; serving = 0;
          e.ins = m.ins; e.pc = saddr;
          e.taken = m.kind == 1 || (m.kind == 2 && bhtm[saddr[9:2]] >= 2);
          e.ppc = e.taken ? saddr + 32'(m.off) : saddr + 32'd4;
          exp_q.push_back(e);
          exp_fetch = e.ppc;
        end else cnt--;
      end
      bp_upd_valid = $urandom_range(0, 2) == 0;
      bp_upd_pc    = $urandom_range(0, 1) == 1 ? saddr : 32'($urandom_range(0, 63) * 4);
      bp_upd_taken = 1'($urandom_range(0, 1));
      if (bp_upd_valid)
        bhtm[bp_upd_pc[9:2]] = bp_upd_taken ? (bhtm[bp_upd_pc[9:2]] < 3 ? bhtm[bp_upd_pc[9:2]] + 1 : 3)
                                            : (bhtm[bp_upd_pc[9:2]] > 0 ? bhtm[bp_upd_pc[9:2]] - 1 : 0);
      dq_full = $urandom_range(0, 3) == 0;
      @(negedge clk);
    end
    chk("rand_progress", 32'(npush > 100), 1);
    do_reset();
    chk_reset("final_reset");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
